// File: rtl/addr4u_exhaustive_checker_if.sv
// -----------------------------------------------------------------------------
// addr4u_exhaustive_checker_if
// Operand/result bus between the exhaustive checker and a 4-bit adder under
// test.
//   op_a    [3:0]  operand A, driven by the checker
//   op_b    [3:0]  operand B, driven by the checker
//   dut_sum [4:0]  {cout, s[3:0]} returned by the adder under test
// master : checker side (drives operands, consumes sum)
// slave  : adder side   (consumes operands, drives sum)
// -----------------------------------------------------------------------------
interface addr4u_exhaustive_checker_if;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [4:0] dut_sum;

  modport master (
    output op_a,
    output op_b,
    input  dut_sum
  );

  modport slave (
    input  op_a,
    input  op_b,
    output dut_sum
  );
endinterface

// File: rtl/addr4u_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// addr4u_exhaustive_checker
// Walks all 256 {A,B} operand pairs through a combinational 4-bit adder,
// samples its 5-bit sum after SETTLE_CYCLES clocks and compares it against
// A+B. Counts mismatches (saturating) and records the first failing vector.
//
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   start            in   launch a 256-vector run (accepted only in IDLE)
//   adder            if   master side of the operand/sum bus
//   busy             out  run in progress (SETTLE or CHECK)
//   done             out  one-cycle pulse at run completion
//   err_strobe       out  one-cycle pulse per detected mismatch
//   err_cnt          out  saturating mismatch count of current/last run
//   first_err_valid  out  a mismatch has been recorded this run
//   first_err_vec    out  {op_a,op_b} of the first mismatch
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; previous results held
// S_SETTLE | operands stable, settle counter running down
// S_CHECK  | compare adder sum against golden A+B, advance vector
// S_DONE   | single cycle with done=1, operands hold 8'hFF
// -----------------------------------------------------------------------------
module addr4u_exhaustive_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  addr4u_exhaustive_checker_if.master  adder,
  output logic                         busy,
  output logic                         done,
  output logic                         err_strobe,
  output logic [CNT_W-1:0]             err_cnt,
  output logic                         first_err_valid,
  output logic [7:0]                   first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  // With no settle time each vector is checked on the cycle after it is driven.
  localparam state_t           S_FIRST   = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;

  state_t           r_state;
  logic [7:0]       r_vec;
  logic [3:0]       r_settle;
  logic             r_busy;
  logic             r_done;
  logic             r_err_strobe;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_first_valid;
  logic [7:0]       r_first_vec;

  logic [4:0]       w_golden;
  logic             w_mismatch;

  // Golden sum is built from the registered operands, i.e. exactly what the
  // adder is currently seeing.
  assign w_golden   = {1'b0, r_vec[7:4]} + {1'b0, r_vec[3:0]};
  assign w_mismatch = (adder.dut_sum != w_golden);

  assign adder.op_a      = r_vec[7:4];
  assign adder.op_b      = r_vec[3:0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign err_strobe      = r_err_strobe;
  assign err_cnt         = r_err_cnt;
  assign first_err_valid = r_first_valid;
  assign first_err_vec   = r_first_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vec         <= 8'd0;
      r_settle      <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_strobe  <= 1'b0;
      r_err_cnt     <= '0;
      r_first_valid <= 1'b0;
      r_first_vec   <= 8'd0;
    end else begin
      r_done       <= 1'b0;
      r_err_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec         <= 8'd0;
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= 8'd0;
            r_settle      <= SETTLE_LD;
            r_busy        <= 1'b1;
            r_state       <= S_FIRST;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle - 4'd1;
          // Counter value 1 marks the last settle cycle.
          if (r_settle <= 4'd1) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err_strobe <= 1'b1;
            if (r_err_cnt != CNT_MAX) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (!r_first_valid) begin
              r_first_valid <= 1'b1;
              r_first_vec   <= r_vec;
            end
          end
          if (r_vec == 8'hFF) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_vec    <= r_vec + 8'd1;
            r_settle <= SETTLE_LD;
            r_state  <= S_FIRST;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
